// File: rtl/async_reset_synchronizer_filter.sv
// Multi-channel input synchronizer with per-channel glitch filter.
// Each io_d bit passes through a DEPTH-stage flop chain; the synchronized bit
// must then disagree with the filtered value for FILTER consecutive cycles
// before io_q follows it. Edge pulses and a global stability flag are
// derived from registers only, so no combinational path exists from io_d.
module async_reset_synchronizer_filter #(
  parameter int               WIDTH  = 1,
  parameter int               DEPTH  = 3,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter int               FILTER = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_stable
);

  // Reject configurations that cannot synchronize or filter.
  if (DEPTH < 2) begin : g_depth_check
    $error("async_reset_synchronizer_filter: DEPTH must be at least 2");
  end
  if (FILTER < 1) begin : g_filter_check
    $error("async_reset_synchronizer_filter: FILTER must be at least 1");
  end

  // Counter holds 0..FILTER-1; a 1-bit counter is kept even for FILTER<=2.
  localparam int            CW      = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

  // Synchronizer chain: index 0 is the first (capturing) stage.
  logic [DEPTH-1:0][WIDTH-1:0] sync_q;
  logic [DEPTH-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]            sync_s;

  // Filter state per channel.
  logic [WIDTH-1:0]         filt_q, filt_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;

  assign sync_d = {sync_q[DEPTH-2:0], io_d};
  assign sync_s = sync_q[DEPTH-1];

  // Shift every channel's bit one stage deeper per clock.
  // NOTE: every stage is reset, not just the output one; reset must leave
  // the whole chain at INIT so no stale pre-reset bit surfaces afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {DEPTH{INIT}};
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      sync_q <= sync_d;
    end
  end

  // Per-channel persistence counter and filtered value with edge detection.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a latch.
    cnt_d  = '0;
    filt_d = filt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Disagreement persisted long enough: accept the new level.
          filt_d[i] = sync_s[i];
          rise_d[i] = sync_s[i];
          fall_d[i] = ~sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Register filter state and the one-cycle edge pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q <= INIT;
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign io_q      = filt_q;
  assign io_rise   = rise_q;
  assign io_fall   = fall_q;
  assign io_stable = (sync_s == filt_q);

endmodule

// File: tb/tb_async_reset_synchronizer_filter.sv
// Self-checking bench: directed tables for the documented scenarios, then a
// randomized run compared against a sliding-window reference model.
module tb_async_reset_synchronizer_filter;

  localparam int W      = 2;
  localparam int DEPTH  = 3;
  localparam int FILTER = 4;
  localparam int NM     = 2;   // model 0: FILTER=4 DUT, model 1: FILTER=1 DUT

  typedef logic [W-1:0] vec_t;

  typedef struct {
    vec_t d;
    vec_t q;
    vec_t rise;
    vec_t fall;
    logic stable;
  } vector_t;

  logic clock = 1'b0;
  logic reset, reset2;
  vec_t io_d, io_d2;
  vec_t q0, r0, f0;
  logic st0;
  vec_t q1, r1, f1;
  logic st1;
  vec_t q2, r2, f2;
  logic st2;

  int checks   = 0;
  int failures = 0;

  async_reset_synchronizer_filter #(.WIDTH(W), .DEPTH(DEPTH), .INIT(2'b00), .FILTER(FILTER)) u_dut (
    .clock(clock), .reset(reset), .io_d(io_d),
    .io_q(q0), .io_rise(r0), .io_fall(f0), .io_stable(st0));

  async_reset_synchronizer_filter #(.WIDTH(W), .DEPTH(DEPTH), .INIT(2'b00), .FILTER(1)) u_f1 (
    .clock(clock), .reset(reset), .io_d(io_d),
    .io_q(q1), .io_rise(r1), .io_fall(f1), .io_stable(st1));

  async_reset_synchronizer_filter #(.WIDTH(W), .DEPTH(DEPTH), .INIT(2'b10), .FILTER(FILTER)) u_init (
    .clock(clock), .reset(reset2), .io_d(io_d2),
    .io_q(q2), .io_rise(r2), .io_fall(f2), .io_stable(st2));

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // io_q changes only when the last N synchronized samples all differ from it.
  int   m_filter [NM] = '{FILTER, 1};
  vec_t m_pipe   [NM][DEPTH];   // [0] = newest captured io_d
  vec_t m_win    [NM][FILTER];  // [0] = newest synchronized sample
  int   m_win_n  [NM];
  vec_t m_f      [NM];
  vec_t m_rise   [NM];
  vec_t m_fall   [NM];

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      for (int k = 0; k < DEPTH; k++) m_pipe[m][k] = '0;
      for (int k = 0; k < FILTER; k++) m_win[m][k] = '0;
      m_win_n[m] = 0;
      m_f[m]     = '0;
      m_rise[m]  = '0;
      m_fall[m]  = '0;
    end
  endtask

  task automatic model_edge(input vec_t d);
    vec_t s;
    bit   all_diff;
    for (int m = 0; m < NM; m++) begin
      s = m_pipe[m][DEPTH-1];
      for (int k = FILTER - 1; k > 0; k--) m_win[m][k] = m_win[m][k-1];
      m_win[m][0] = s;
      if (m_win_n[m] < FILTER) m_win_n[m]++;
      m_rise[m] = '0;
      m_fall[m] = '0;
      for (int i = 0; i < W; i++) begin
        all_diff = (m_win_n[m] >= m_filter[m]);
        for (int k = 0; k < m_filter[m]; k++)
          if (m_win[m][k][i] == m_f[m][i]) all_diff = 1'b0;
        if (all_diff) begin
          m_rise[m][i] = s[i];
          m_fall[m][i] = ~s[i];
          m_f[m][i]    = s[i];
        end
      end
      for (int k = DEPTH - 1; k > 0; k--) m_pipe[m][k] = m_pipe[m][k-1];
      m_pipe[m][0] = d;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_edge(io_d);
    #1;
  endtask

  task automatic check_main(input string tag, input vec_t q, input vec_t rs,
                            input vec_t fl, input logic st);
    check({tag, ".q"},      q0,  q);
    check({tag, ".rise"},   r0,  rs);
    check({tag, ".fall"},   f0,  fl);
    check({tag, ".stable"}, st0, st);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},       q0,  m_f[0]);
    check({tag, ".rise"},    r0,  m_rise[0]);
    check({tag, ".fall"},    f0,  m_fall[0]);
    check({tag, ".stable"},  st0, m_pipe[0][DEPTH-1] == m_f[0]);
    check({tag, ".f1q"},     q1,  m_f[1]);
    check({tag, ".f1rise"},  r1,  m_rise[1]);
    check({tag, ".f1fall"},  f1,  m_fall[1]);
    check({tag, ".f1stable"}, st1, m_pipe[1][DEPTH-1] == m_f[1]);
  endtask

  vector_t vec_b [9];

  initial begin
    // Rising step on channel 0: synchronizer latency 3, filter 4 more edges.
    vec_b[0] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
    vec_b[1] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
    vec_b[2] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    vec_b[3] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    vec_b[4] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    vec_b[5] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    vec_b[6] = '{2'b01, 2'b01, 2'b01, 2'b00, 1'b1};
    vec_b[7] = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b1};
    vec_b[8] = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b1};

    // Reset with io_d=11 held: outputs at INIT before any edge.
    reset  = 1'b1;
    reset2 = 1'b1;
    io_d   = 2'b11;
    io_d2  = 2'b10;
    model_reset();
    #1;
    check_main("A.inreset", 2'b00, 2'b00, 2'b00, 1'b1);
    #1;
    reset  = 1'b0;
    reset2 = 1'b0;
    tick();
    check_main("A.edge1", 2'b00, 2'b00, 2'b00, 1'b1);

    // Clear the captured 1s, then run the rising-step table.
    reset = 1'b1;
    model_reset();
    io_d = 2'b00;
    #1;
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      io_d = vec_b[k].d;
      tick();
      check_main($sformatf("B[%0d]", k), vec_b[k].q, vec_b[k].rise, vec_b[k].fall, vec_b[k].stable);
    end

    // Bring io_q to 11, then drop both channels together.
    io_d = 2'b11;
    for (int k = 1; k <= 8; k++) tick();
    check_main("C.setup", 2'b11, 2'b00, 2'b00, 1'b1);
    io_d = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check({"C.hold", $sformatf("%0d", k)}, q0, 2'b11);
    end
    tick();
    check_main("C.edge7", 2'b00, 2'b00, 2'b11, 1'b1);
    tick();
    check_main("C.edge8", 2'b00, 2'b00, 2'b00, 1'b1);

    // Three-cycle glitch on channel 1 must be rejected.
    for (int k = 1; k <= 12; k++) begin
      io_d = (k <= 3) ? 2'b10 : 2'b00;
      tick();
      check($sformatf("D[%0d].q", k), q0, 2'b00);
      check($sformatf("D[%0d].edges", k), {r0, f0}, 4'b0000);
    end
    check("D.stable", st0, 1'b1);

    // Reset in the middle of a count discards it.
    io_d = 2'b01;
    for (int k = 1; k <= 5; k++) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_main("E.inreset", 2'b00, 2'b00, 2'b00, 1'b1);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("E.post[%0d].q", k), q0, 2'b00);
    end
    tick();
    check_main("E.edge7", 2'b01, 2'b01, 2'b00, 1'b1);

    // Randomized run against the model, with occasional async resets.
    reset = 1'b1;
    io_d  = 2'b00;
    model_reset();
    #1;
    reset = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int hold;
      hold = $urandom_range(1, 7);
      io_d = vec_t'($urandom);
      for (int h = 0; h < hold; h++) begin
        tick();
        check_model("R");
        if ($urandom_range(0, 199) == 0) begin
          reset = 1'b1;
          model_reset();
          #1;
          check_model("R.reset");
          reset = 1'b0;
        end
      end
    end

    // Non-zero INIT held on the input: never moves, never pulses.
    reset2 = 1'b1;
    #1;
    check("F.inreset.q", q2, 2'b10);
    check("F.inreset.stable", st2, 1'b1);
    reset2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("F[%0d].q", k), q2, 2'b10);
      check($sformatf("F[%0d].edges", k), {r2, f2}, 4'b0000);
      check($sformatf("F[%0d].stable", k), st2, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_reset_synchronizer_filter.md
ASYNC_RESET_SYNCHRONIZER_FILTER -- requirements
Module: async_reset_synchronizer_filter

Interface
REQ-001 Parameter WIDTH, default 1, number of independent single-bit channels.
REQ-002 Parameter DEPTH, default 3, synchronizer flop stages per channel; values below 2 SHALL fail elaboration.
REQ-003 Parameter INIT, default 0 (WIDTH bits), reset value of every channel's chain, filter state and io_q.
REQ-004 Parameter FILTER, default 4, consecutive disagreeing cycles required before io_q updates; values below 1 SHALL fail elaboration.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 io_d  input  WIDTH  asynchronous input bits, one per channel.
REQ-008 io_q  output  WIDTH  synchronized, glitch-filtered value.
REQ-009 io_rise  output  WIDTH  one-cycle pulse per channel when io_q bit goes 0->1.
REQ-010 io_fall  output  WIDTH  one-cycle pulse per channel when io_q bit goes 1->0.
REQ-011 io_stable  output  1  high when every channel's synchronized value equals its io_q bit.

Function
REQ-012 Each channel SHALL have a DEPTH-flop shift chain; io_d[i] enters stage 1, s[i] = last stage; io_d-to-s latency exactly DEPTH edges.
REQ-013 No combinational path from io_d to any output.
REQ-014 Each channel SHALL hold filtered state f[i] (drives io_q[i]) and a counter c[i] of ceil(log2(FILTER)) bits (min 1).
REQ-015 Per edge: s[i]==f[i] -> c[i]<=0; s[i]!=f[i] and c[i]<FILTER-1 -> c[i]<=c[i]+1; s[i]!=f[i] and c[i]==FILTER-1 -> f[i]<=s[i], c[i]<=0.
REQ-016 c[i] SHALL never exceed FILTER-1; no wrap-around.
REQ-017 Clean step on io_d[i] (held) SHALL appear on io_q[i] exactly DEPTH+FILTER edges after first capture.
REQ-018 Disagreement lasting fewer than FILTER consecutive cycles SHALL clear c[i] and leave io_q[i] unchanged (glitch rejection); one agreeing cycle restarts the count.
REQ-019 io_rise[i]/io_fall[i] SHALL be registered, asserted in exactly the cycle io_q[i] first shows the new value, low otherwise.
REQ-020 io_stable = AND over i of (s[i]==f[i]), derived from registers only.
REQ-021 Channels SHALL be fully independent; simultaneous updates on multiple channels produce simultaneous pulses.
REQ-022 FILTER=1 SHALL give io_q = s delayed one edge.

Reset
REQ-023 reset high SHALL immediately, without a clock edge, force all chain stages and f to INIT, c to 0, io_rise and io_fall to 0.
REQ-024 During and immediately after reset, io_q=INIT and io_stable=1.
REQ-025 Reset mid-count SHALL discard partial counts; no pulse SHALL be generated by reset assertion or release.
REQ-026 Release SHALL be usable with no minimum clocks in reset; first capture occurs on the first edge after release.

Verification (WIDTH=2, DEPTH=3, FILTER=4, INIT=0 unless noted)
REQ-027 Reset with io_d=11 held -> io_q=00, io_rise=io_fall=00, io_stable=1 before any edge and on the first edge after release.
REQ-028 io_d 00->01 before edge 1 -> io_stable=0 after edge 3, io_q=01 and io_rise=01 after edge 7 only, io_rise=00 after edge 8, io_stable=1 after edge 7.
REQ-029 io_d[1] pulsed high for 3 cycles then low -> io_q stays 00, io_rise/io_fall stay 00, io_stable returns to 1.
REQ-030 From io_q=11, io_d->00 before edge 1 -> io_q=00 and io_fall=11 in the same cycle, after edge 7.
REQ-031 reset asserted mid-cycle while c[0]=2 -> io_q=00 and io_stable=1 before the next edge; after release with io_d=01 held, io_q=01 after edge 7 counted from release.
REQ-032 INIT=10, io_d=10 held through and after reset -> io_q=10 throughout, no pulses, io_stable=1 for 20 cycles.
